// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync polarity codes and the control bundle
// carried through the renderer-latency pipeline.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned SYNC_ACT_LOW  = 0;
    localparam int unsigned SYNC_ACT_HIGH = 1;

    localparam int unsigned REQ_W = 10;

    // Sync levels are stored already polarity-adjusted; active is the raw DE flag.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } vga_ctl_t;

    function automatic int unsigned timing_total(input int unsigned active_len,
                                                 input int unsigned fp_len,
                                                 input int unsigned sync_len,
                                                 input int unsigned bp_len);
        return active_len + fp_len + sync_len + bp_len;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift-enabled register pipeline with a synchronous active-low clear that
// loads a configurable idle pattern into every stage.
module vga_delay_line #(
    parameter int unsigned          WIDTH   = 3,
    parameter int unsigned          DEPTH   = 1,
    parameter logic [WIDTH-1:0]     CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= CLR_VAL;
            end
        end else if (shift) begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, h/v counters,
// renderer requests and a latency-matched sync/DE/colour output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned H_POL    = SYNC_ACT_LOW,
    parameter int unsigned V_POL    = SYNC_ACT_LOW,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned PIX_LAT  = 1,
    parameter int unsigned COLOR_W  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [9:0]         req_x,
    output logic [9:0]         req_y,
    output logic               req_valid,
    output logic               pix_tick,
    input  logic [COLOR_W-1:0] pixel_r,
    input  logic [COLOR_W-1:0] pixel_g,
    input  logic [COLOR_W-1:0] pixel_b,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               frame_start,
    output logic               line_start
);

    localparam int unsigned H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic             HS_ON    = (H_POL != 0);
    localparam logic             VS_ON    = (V_POL != 0);
    localparam vga_ctl_t         CTL_IDLE = '{hsync: ~HS_ON, vsync: ~VS_ON, active: 1'b0};

    if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_bad_active
        $error("vga_timing_gen: H_ACTIVE and V_ACTIVE must not exceed 1024");
    end
    if (CLK_DIV < 1 || PIX_LAT < 1) begin : g_bad_div_lat
        $error("vga_timing_gen: CLK_DIV and PIX_LAT must be at least 1");
    end

    logic             run;
    logic [DIV_W-1:0] div;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic             h_act;
    logic             v_act;
    vga_ctl_t         ctl_raw;
    vga_ctl_t         ctl_dly;

    // Disabling behaves exactly like reset, so both gate the whole datapath.
    assign run      = reset_n & enable;
    assign pix_tick = run && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!run) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            if (pix_tick) begin
                if (32'(h) == H_TOTAL - 1) begin
                    h <= '0;
                    v <= (32'(v) == V_TOTAL - 1) ? '0 : v + V_W'(1);
                end else begin
                    h <= h + H_W'(1);
                end
            end
        end
    end

    assign h_act       = (32'(h) < H_ACTIVE);
    assign v_act       = (32'(v) < V_ACTIVE);
    assign req_valid   = run && h_act && v_act;
    assign req_x       = req_valid ? REQ_W'(h) : '0;
    assign req_y       = req_valid ? REQ_W'(v) : '0;
    assign frame_start = pix_tick && (h == '0) && (v == '0);
    assign line_start  = pix_tick && (h == '0) && v_act;

    always_comb begin
        ctl_raw        = CTL_IDLE;
        ctl_raw.active = req_valid;
        if (32'(h) >= HS_START && 32'(h) < HS_END) begin
            ctl_raw.hsync = HS_ON;
        end
        if (32'(v) >= VS_START && 32'(v) < VS_END) begin
            ctl_raw.vsync = VS_ON;
        end
    end

    // The output register below is the last of the PIX_LAT stages; the
    // pipeline ahead of it supplies the remaining PIX_LAT-1.
    if (PIX_LAT > 1) begin : g_dly
        vga_delay_line #(
            .WIDTH   ($bits(vga_ctl_t)),
            .DEPTH   (PIX_LAT - 1),
            .CLR_VAL (CTL_IDLE)
        ) u_delay_line (
            .clk     (clk),
            .clear_n (run),
            .shift   (pix_tick),
            .din     (ctl_raw),
            .dout    (ctl_dly)
        );
    end else begin : g_no_dly
        assign ctl_dly = ctl_raw;
    end

    // Renderer data arrives alongside the delayed flags, so both load on one edge.
    always_ff @(posedge clk) begin
        if (!run) begin
            hsync <= CTL_IDLE.hsync;
            vsync <= CTL_IDLE.vsync;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (pix_tick) begin
            hsync <= ctl_dly.hsync;
            vsync <= ctl_dly.vsync;
            de    <= ctl_dly.active;
            red   <= ctl_dly.active ? pixel_r : '0;
            green <= ctl_dly.active ? pixel_g : '0;
            blue  <= ctl_dly.active ? pixel_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using two small-timing instances:
// A (CLK_DIV=2, PIX_LAT=1, active-low sync) and B (CLK_DIV=1, PIX_LAT=3, active-high sync).
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic enable;

    logic [9:0] a_rx, a_ry;
    logic       a_rv, a_tick, a_hs, a_vs, a_de, a_fs, a_ls;
    logic [3:0] a_r, a_g, a_b, a_pr, a_pg;

    logic [9:0] b_rx, b_ry, b_rx1, b_rx2;
    logic       b_rv, b_tick, b_hs, b_vs, b_de, b_fs, b_ls;
    logic [3:0] b_r, b_g, b_b, b_pr;

    assign a_pr = a_rx[3:0];
    assign a_pg = a_ry[3:0];
    assign b_pr = b_rx2[3:0];

    // Renderer for B: two extra clock registers give 3 ticks of latency at CLK_DIV=1.
    always @(posedge clk) begin
        b_rx1 <= b_rx;
        b_rx2 <= b_rx1;
    end

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .CLK_DIV(2), .PIX_LAT(1), .COLOR_W(4)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_x(a_rx), .req_y(a_ry), .req_valid(a_rv), .pix_tick(a_tick),
        .pixel_r(a_pr), .pixel_g(a_pg), .pixel_b(4'hF),
        .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .red(a_r), .green(a_g), .blue(a_b),
        .frame_start(a_fs), .line_start(a_ls)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .CLK_DIV(1), .PIX_LAT(3), .COLOR_W(4)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_x(b_rx), .req_y(b_ry), .req_valid(b_rv), .pix_tick(b_tick),
        .pixel_r(b_pr), .pixel_g(4'h0), .pixel_b(4'hF),
        .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .red(b_r), .green(b_g), .blue(b_b),
        .frame_start(b_fs), .line_start(b_ls)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Instance A expectations, cycle c counted from the first cycle after reset release.
    typedef struct {
        int cyc;
        bit tick, fs, ls, rv;
        int rx, ry;
        bit hs, vs, de;
        int r, g;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    task automatic check_vec(input vec_t t);
        string p;
        p = $sformatf("A c%0d", t.cyc);
        chk({p, " pix_tick"},    int'(a_tick), int'(t.tick));
        chk({p, " frame_start"}, int'(a_fs),   int'(t.fs));
        chk({p, " line_start"},  int'(a_ls),   int'(t.ls));
        chk({p, " req_valid"},   int'(a_rv),   int'(t.rv));
        chk({p, " req_x"},       int'(a_rx),   t.rx);
        chk({p, " req_y"},       int'(a_ry),   t.ry);
        chk({p, " hsync"},       int'(a_hs),   int'(t.hs));
        chk({p, " vsync"},       int'(a_vs),   int'(t.vs));
        chk({p, " de"},          int'(a_de),   int'(t.de));
        chk({p, " red"},         int'(a_r),    t.r);
        chk({p, " green"},       int'(a_g),    t.g);
        chk({p, " blue"},        int'(a_b),    t.de ? 15 : 0);
    endtask

    // B outputs {hsync, vsync, de, red} for cycle c after release (output lags counters by 3).
    function automatic int b_model(input int c);
        int q, hq, vq;
        bit d;
        if (c < 3) return 0;
        q  = c - 3;
        hq = q % 12;
        vq = (q / 12) % 7;
        d  = (hq < 8) && (vq < 4);
        return ((hq >= 9 && hq < 11) ? 64 : 0) + ((vq == 5) ? 32 : 0)
             + (d ? 16 : 0) + (d ? hq : 0);
    endfunction

    function automatic int a_pack();
        return {25'd0, a_hs, a_vs, a_de, a_r, a_b, a_rv, a_tick};
    endfunction

    function automatic int b_pack();
        return {26'd0, b_hs, b_vs, b_de, b_r, b_rv};
    endfunction

    initial begin
        int ti, b_first_de;
        int a_hs_lo, a_de_hi, a_vs_lo, a_ls_n, a_fs_n, a_blue_bad;
        int b_bad, b_ls_n, b_fs_n;

        tbl[0]  = '{0,   0,0,0,1, 0,0, 1,1,0, 0,0};
        tbl[1]  = '{1,   1,1,1,1, 0,0, 1,1,0, 0,0};
        tbl[2]  = '{2,   0,0,0,1, 1,0, 1,1,1, 0,0};
        tbl[3]  = '{4,   0,0,0,1, 2,0, 1,1,1, 1,0};
        tbl[4]  = '{18,  0,0,0,0, 0,0, 1,1,0, 0,0};
        tbl[5]  = '{20,  0,0,0,0, 0,0, 0,1,0, 0,0};
        tbl[6]  = '{23,  1,0,0,0, 0,0, 0,1,0, 0,0};
        tbl[7]  = '{24,  0,0,0,1, 0,1, 1,1,0, 0,0};
        tbl[8]  = '{25,  1,0,1,1, 0,1, 1,1,0, 0,0};
        tbl[9]  = '{27,  1,0,0,1, 1,1, 1,1,1, 0,1};
        tbl[10] = '{86,  0,0,0,1, 7,3, 1,1,1, 6,3};
        tbl[11] = '{98,  0,0,0,0, 0,0, 1,1,0, 0,0};
        tbl[12] = '{122, 0,0,0,0, 0,0, 1,0,0, 0,0};
        tbl[13] = '{145, 1,0,0,0, 0,0, 1,0,0, 0,0};
        tbl[14] = '{146, 0,0,0,0, 0,0, 1,1,0, 0,0};
        tbl[15] = '{169, 1,1,1,1, 0,0, 1,1,0, 0,0};
        tbl[16] = '{170, 0,0,0,1, 1,0, 1,1,1, 0,0};

        ti = 0; b_first_de = -1;
        a_hs_lo = 0; a_de_hi = 0; a_vs_lo = 0; a_ls_n = 0; a_fs_n = 0; a_blue_bad = 0;
        b_bad = 0; b_ls_n = 0; b_fs_n = 0;

        // Reset values
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset A {hs,vs,de,r,b,rv,tick}", a_pack(), 13'b1100000000000);
        chk("reset B {hs,vs,de,r,rv}",        b_pack(), 0);
        chk("reset A frame_start", int'(a_fs), 0);
        chk("reset B frame_start", int'(b_fs), 0);

        // Two full frames of A against the table, B against its latency model
        reset_n = 1'b1;
        for (int c = 0; c < 340; c++) begin
            #1;
            if (ti < NVEC && tbl[ti].cyc == c) begin
                check_vec(tbl[ti]);
                ti++;
            end
            if (c >= 2 && c < 338) begin
                if (!a_hs) a_hs_lo++;
                if (a_de)  a_de_hi++;
                if (!a_vs) a_vs_lo++;
            end
            if (c < 336) begin
                if (a_ls) a_ls_n++;
                if (a_fs) a_fs_n++;
                if (b_ls) b_ls_n++;
                if (b_fs) b_fs_n++;
            end
            if (int'(a_b) != (a_de ? 15 : 0) || (!a_de && a_r != 4'h0)) a_blue_bad++;
            if (int'({b_hs, b_vs, b_de, b_r}) != b_model(c)) b_bad++;
            if (b_de && b_first_de < 0) b_first_de = c;
            @(posedge clk);
            #1;
        end
        chk("A table rows reached",        ti,         NVEC);
        chk("A hsync low clks, 2 frames",  a_hs_lo,    56);
        chk("A de high clks, 2 frames",    a_de_hi,    128);
        chk("A vsync low clks, 2 frames",  a_vs_lo,    48);
        chk("A line_start pulses",         a_ls_n,     8);
        chk("A frame_start pulses",        a_fs_n,     2);
        chk("A colour blanking errors",    a_blue_bad, 0);
        chk("B model mismatch cycles",     b_bad,      0);
        chk("B first de cycle",            b_first_de, 3);
        chk("B line_start pulses",         b_ls_n,     16);
        chk("B frame_start pulses",        b_fs_n,     4);

        // Reset pulsed mid-frame at A position (5,2)
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 58; c++) begin
            @(posedge clk);
            #1;
        end
        #1;
        chk("midreset A req_x before", int'(a_rx), 5);
        chk("midreset A req_y before", int'(a_ry), 2);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset A regs on edge", a_pack(), 13'b1100000000000);
        chk("midreset B regs on edge", b_pack(), 0);
        chk("midreset A frame_start low", int'(a_fs), 0);
        reset_n = 1'b1;
        #1;
        chk("release A c0 tick",        int'(a_tick), 0);
        chk("release A c0 req {v,x,y}", int'({a_rv, a_rx, a_ry}), 1 << 20);
        chk("release B c0 frame_start", int'(b_fs), 1);
        @(posedge clk);
        #1;
        chk("release A c1 frame_start", int'(a_fs), 1);
        chk("release A c1 line_start",  int'(a_ls), 1);
        @(posedge clk);
        #1;
        chk("release A c2 {hs,vs,de,r,b,rv,tick}", a_pack(), 13'b1110000111110);

        // Enable dropped mid-line for 10 clocks
        repeat (7) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("enable low A clk%0d", i), a_pack(), 13'b1100000000000);
            chk($sformatf("enable low B clk%0d", i), b_pack(), 0);
        end
        enable = 1'b1;
        #1;
        chk("re-enable A c0 {rv,tick,fs}", int'({a_rv, a_tick, a_fs}), 3'b100);
        chk("re-enable B c0 frame_start",  int'(b_fs), 1);
        @(posedge clk);
        #1;
        chk("re-enable A c1 frame_start",  int'(a_fs), 1);
        chk("re-enable A c1 de",           int'(a_de), 0);
        @(posedge clk);
        #1;
        chk("re-enable A c2 {hs,vs,de,r,b,rv,tick}", a_pack(), 13'b1110000111110);

        // reset_n and enable both low
        reset_n = 1'b0;
        enable  = 1'b0;
        @(posedge clk);
        #1;
        chk("both low A", a_pack(), 13'b1100000000000);
        chk("both low B", b_pack(), 0);
        chk("both low A frame_start", int'(a_fs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
